// File: rtl/ofm_requant_collector.sv
// rtl/ofm_requant_collector.sv - per-column sum FIFOs, int8 requant, round-robin drain to one stream
// Each column has its own FIFO; the arbiter pops one column per cycle into a registered output.
module ofm_requant_collector #(
  parameter int COL        = 8,
  parameter int SUM_WIDTH  = 26,
  parameter int FIFO_DEPTH = 16,
  parameter int TILE_LEN   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     cfg_relu,
  input  logic [4:0]               cfg_shift,
  input  logic [COL*SUM_WIDTH-1:0] sum,
  input  logic [COL-1:0]           sum_valid,
  output logic [7:0]               ofm_data,
  output logic [$clog2(COL)-1:0]   ofm_col,
  output logic                     ofm_last,
  output logic                     ofm_valid,
  input  logic                     ofm_ready,
  output logic [COL-1:0]           overflow,
  output logic                     empty
);

  localparam int CW = $clog2(COL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
  // Wide enough that adding a rounding constant of up to 2^30 can never wrap.
  localparam int RW = SUM_WIDTH + 33;
  localparam logic signed [RW-1:0] MAX_V = 127;
  localparam logic signed [RW-1:0] MIN_V = -128;

  logic [SUM_WIDTH-1:0] mem_q [COL][FIFO_DEPTH];
  logic [AW:0]          wptr_q [COL];
  logic [AW:0]          rptr_q [COL];
  logic [LW-1:0]        line_q [COL];
  logic [CW-1:0]        rr_q;
  logic [7:0]           data_q;
  logic [CW-1:0]        col_q;
  logic                 last_q;
  logic                 valid_q;
  logic [COL-1:0]       ovf_q;

  logic [COL-1:0] fifo_empty;
  logic [COL-1:0] fifo_full;
  logic [COL-1:0] push;
  logic [COL-1:0] pop;
  logic [COL-1:0] drop;
  logic           load;
  logic           grant_found;
  logic [CW-1:0]  grant;
  logic [CW-1:0]  idx;
  logic [CW-1:0]  rr_d;
  logic [LW-1:0]  line_d;
  logic           last_d;

  logic [SUM_WIDTH-1:0]  head;
  logic signed [RW-1:0]  s_w;
  logic signed [RW-1:0]  rnd_w;
  logic signed [RW-1:0]  acc_w;
  logic signed [RW-1:0]  r_w;
  logic [7:0]            data_d;

  assign load = !valid_q || ofm_ready;

  always_comb begin
    for (int i = 0; i < COL; i++) begin
      fifo_empty[i] = (wptr_q[i] == rptr_q[i]);
      fifo_full[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                      (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
    end
  end

  // Walk from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = COL - 1; k >= 0; k--) begin
      idx = CW'((int'(rr_q) + k) % COL);
      if (!fifo_empty[idx]) begin
        grant       = idx;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < COL; i++) begin
      pop[i]  = load && grant_found && (grant == CW'(i));
      push[i] = !clear && sum_valid[i] && (!fifo_full[i] || pop[i]);
      drop[i] = sum_valid[i] && fifo_full[i] && !pop[i];
    end
  end

  always_comb begin
    head  = mem_q[grant][rptr_q[grant][AW-1:0]];
    s_w   = {{(RW-SUM_WIDTH){head[SUM_WIDTH-1]}}, head};
    if (cfg_relu && s_w[RW-1]) s_w = '0;
    rnd_w = RW'(1) << (cfg_shift - 5'd1);
    acc_w = s_w + rnd_w;
    r_w   = (cfg_shift == 5'd0) ? s_w : (acc_w >>> cfg_shift);
    if (r_w > MAX_V)      data_d = 8'h7f;
    else if (r_w < MIN_V) data_d = 8'h80;
    else                  data_d = r_w[7:0];
  end

  always_comb begin
    last_d = (line_q[grant] == LW'(TILE_LEN - 1));
    line_d = last_d ? '0 : line_q[grant] + 1'b1;
    rr_d   = (grant == CW'(COL - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < COL; i++) begin
      if (push[i]) mem_q[i][wptr_q[i][AW-1:0]] <= sum[i*SUM_WIDTH +: SUM_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < COL; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        line_q[i] <= '0;
      end
      rr_q    <= '0;
      data_q  <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else if (clear) begin
      for (int i = 0; i < COL; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        line_q[i] <= '0;
      end
      rr_q    <= '0;
      data_q  <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      for (int i = 0; i < COL; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
        if (drop[i]) ovf_q[i]  <= 1'b1;
      end
      if (load) begin
        valid_q <= grant_found;
        if (grant_found) begin
          data_q        <= data_d;
          col_q         <= grant;
          last_q        <= last_d;
          line_q[grant] <= line_d;
          rr_q          <= rr_d;
        end
      end
    end
  end

  assign ofm_data  = data_q;
  assign ofm_col   = col_q;
  assign ofm_last  = last_q;
  assign ofm_valid = valid_q;
  assign overflow  = ovf_q;
  assign empty     = (&fifo_empty) && !valid_q;

endmodule

// File: tb/tb_ofm_requant_collector.sv
// tb/tb_ofm_requant_collector.sv - directed table, corner sequences and random run against a queue model
module tb_ofm_requant_collector;

  localparam int COL   = 8;
  localparam int SW    = 26;
  localparam int DEPTH = 16;
  localparam int TILE  = 16;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                clear = 1'b0;
  logic                cfg_relu = 1'b0;
  logic [4:0]          cfg_shift = 5'd0;
  logic [COL*SW-1:0]   sum = '0;
  logic [COL-1:0]      sum_valid = '0;
  logic [7:0]          ofm_data;
  logic [2:0]          ofm_col;
  logic                ofm_last;
  logic                ofm_valid;
  logic                ofm_ready = 1'b1;
  logic [COL-1:0]      overflow;
  logic                empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ofm_requant_collector #(
    .COL(COL), .SUM_WIDTH(SW), .FIFO_DEPTH(DEPTH), .TILE_LEN(TILE)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .sum(sum), .sum_valid(sum_valid), .ofm_data(ofm_data), .ofm_col(ofm_col),
    .ofm_last(ofm_last), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
    .overflow(overflow), .empty(empty)
  );

  // Reference model: one queue of raw sums per column plus the output word.
  longint     mq [COL][$];
  bit         m_valid;
  logic [7:0] m_data;
  int         m_col;
  bit         m_last;
  int         m_rr;
  int         m_line [COL];
  logic [COL-1:0] m_ovf;

  function automatic logic [7:0] rq(longint s, bit relu, int sh);
    longint r;
    if (relu && s < 0) s = 0;
    if (sh == 0) r = s;
    else r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COL; c++) begin
      mq[c].delete();
      m_line[c] = 0;
    end
    m_valid = 0; m_data = '0; m_col = 0; m_last = 0; m_rr = 0; m_ovf = '0;
  endtask

  task automatic model_step();
    int g;
    bit ld;
    bit [COL-1:0] full;
    longint v;
    if (clear) begin
      model_reset();
      return;
    end
    ld = !m_valid || ofm_ready;
    g = -1;
    if (ld) begin
      for (int k = 0; k < COL; k++) begin
        int c;
        c = (m_rr + k) % COL;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
    end
    for (int c = 0; c < COL; c++) full[c] = (mq[c].size() >= DEPTH);
    if (g >= 0) begin
      v = mq[g].pop_front();
      m_data = rq(v, cfg_relu, int'(cfg_shift));
      m_col = g;
      m_last = (m_line[g] == TILE - 1);
      m_line[g] = (m_line[g] + 1) % TILE;
      m_rr = (g + 1) % COL;
    end
    if (ld) m_valid = (g >= 0);
    for (int c = 0; c < COL; c++) begin
      if (sum_valid[c]) begin
        if (!full[c] || g == c) mq[c].push_back(longint'($signed(sum[c*SW +: SW])));
        else m_ovf[c] = 1'b1;
      end
    end
  endtask

  function automatic bit m_empty();
    for (int c = 0; c < COL; c++) if (mq[c].size() != 0) return 0;
    return !m_valid;
  endfunction

  always @(posedge clk) if (rstn) model_step();
  always @(negedge rstn) model_reset();

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input int c, input longint v);
    sum[c*SW +: SW] = v[SW-1:0];
    sum_valid[c] = 1'b1;
  endtask

  task automatic pulse_clear();
    sum_valid = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, ofm_valid, 0);
    chk({tag, "_data"}, ofm_data, 0);
    chk({tag, "_col"}, ofm_col, 0);
    chk({tag, "_last"}, ofm_last, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_empty"}, empty, 1);
  endtask

  function automatic longint rand_sum();
    logic [SW-1:0] r;
    r = SW'($urandom);
    if ($urandom_range(0, 1) == 1) return longint'($signed(r));
    return longint'($urandom_range(0, 6000)) - 3000;
  endfunction

  typedef struct {
    int         col;
    longint     s;
    int         sh;
    bit         relu;
    logic [7:0] exp;
  } vec_t;

  vec_t tv [15];

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int rate;
    model_reset();

    tv[0]  = '{col:2, s:1000,      sh:3,  relu:1'b0, exp:8'h7d};
    tv[1]  = '{col:0, s:8,         sh:4,  relu:1'b0, exp:8'h01};
    tv[2]  = '{col:1, s:-8,        sh:4,  relu:1'b0, exp:8'h00};
    tv[3]  = '{col:4, s:-9,        sh:4,  relu:1'b0, exp:8'hff};
    tv[4]  = '{col:5, s:5000,      sh:4,  relu:1'b0, exp:8'h7f};
    tv[5]  = '{col:6, s:-5000,     sh:4,  relu:1'b0, exp:8'h80};
    tv[6]  = '{col:7, s:-5000,     sh:4,  relu:1'b1, exp:8'h00};
    tv[7]  = '{col:3, s:100,       sh:0,  relu:1'b0, exp:8'h64};
    tv[8]  = '{col:2, s:-129,      sh:0,  relu:1'b0, exp:8'h80};
    tv[9]  = '{col:0, s:33554431,  sh:31, relu:1'b0, exp:8'h00};
    tv[10] = '{col:1, s:-33554432, sh:25, relu:1'b0, exp:8'hff};
    tv[11] = '{col:4, s:3,         sh:1,  relu:1'b0, exp:8'h02};
    tv[12] = '{col:5, s:-3,        sh:1,  relu:1'b0, exp:8'hff};
    tv[13] = '{col:6, s:2039,      sh:4,  relu:1'b0, exp:8'h7f};
    tv[14] = '{col:7, s:2023,      sh:4,  relu:1'b0, exp:8'h7e};

    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    rstn = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    for (int i = 0; i < 15; i++) begin
      sum_valid = '0;
      put(tv[i].col, tv[i].s);
      cfg_shift = 5'(tv[i].sh);
      cfg_relu  = tv[i].relu;
      ofm_ready = 1'b1;
      tick();
      sum_valid = '0;
      chk("tv_no_bypass", ofm_valid, 0);
      tick();
      chk("tv_valid", ofm_valid, 1);
      chk("tv_data", ofm_data, tv[i].exp);
      chk("tv_col", ofm_col, tv[i].col);
      chk("tv_last", ofm_last, 0);
      tick();
      chk("tv_one_cycle", ofm_valid, 0);
    end

    cfg_shift = 5'd0;
    cfg_relu  = 1'b0;
    pulse_clear();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < COL; c++) put(c, c);
      tick();
      sum_valid = '0;
      for (int c = 0; c < COL; c++) begin
        tick();
        chk("arb_valid", ofm_valid, 1);
        chk("arb_col", ofm_col, c);
        chk("arb_data", ofm_data, c);
      end
      tick();
      chk("arb_idle", ofm_valid, 0);
    end

    pulse_clear();
    ofm_ready = 1'b0;
    for (int t = 0; t < 10; t++) begin
      sum_valid = '0;
      if (t < 5) put(0, 10 * (t + 1));
      tick();
      if (t >= 1) begin
        chk("bp_hold_valid", ofm_valid, 1);
        chk("bp_hold_data", ofm_data, 10);
        chk("bp_hold_col", ofm_col, 0);
      end
    end
    sum_valid = '0;
    ofm_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("bp_drain_valid", ofm_valid, 1);
      chk("bp_drain_data", ofm_data, 10 * (j + 1));
      tick();
    end
    chk("bp_done_valid", ofm_valid, 0);
    chk("bp_ovf", overflow, 0);
    chk("bp_empty", empty, 1);

    pulse_clear();
    ofm_ready = 1'b0;
    put(0, 77);
    tick();
    for (int n = 1; n <= 17; n++) begin
      sum_valid = '0;
      put(1, n);
      tick();
      if (n == 16) chk("ovf_at_depth", overflow, 0);
      if (n == 17) chk("ovf_set", overflow, 8'h02);
    end
    sum_valid = '0;
    repeat (3) begin
      tick();
      chk("ovf_sticky", overflow, 8'h02);
    end
    chk("ovf_out_col", ofm_col, 0);
    chk("ovf_out_data", ofm_data, 77);
    pulse_clear();
    chk("clr_ovf", overflow, 0);
    chk("clr_empty", empty, 1);
    chk("clr_valid", ofm_valid, 0);
    ofm_ready = 1'b1;
    clear = 1'b1;
    put(1, 5);
    tick();
    clear = 1'b0;
    sum_valid = '0;
    tick();
    chk("clr_prio_valid", ofm_valid, 0);
    chk("clr_prio_empty", empty, 1);

    cnt = 0;
    for (int t = 0; t < 40; t++) begin
      sum_valid = '0;
      if (t < 32) put(3, t + 1);
      tick();
      if (ofm_valid) begin
        cnt++;
        chk("tile_col", ofm_col, 3);
        chk("tile_data", ofm_data, cnt);
        chk("tile_last", ofm_last, (cnt == 16 || cnt == 32));
      end
    end
    chk("tile_count", cnt, 32);

    ofm_ready = 1'b0;
    sum_valid = '0;
    put(3, 55);
    tick();
    put(3, 56);
    tick();
    sum_valid = '0;
    chk("rst_pre_valid", ofm_valid, 1);
    chk("rst_pre_data", ofm_data, 55);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    rstn = 1'b1;
    ofm_ready = 1'b1;
    tick();
    chk("rst_flushed", ofm_valid, 0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rate = (cyc < 1500) ? 10 : 22;
      sum_valid = '0;
      for (int c = 0; c < COL; c++) begin
        if ($urandom_range(0, 99) < rate) put(c, rand_sum());
      end
      ofm_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        cfg_shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
        cfg_relu  = 1'($urandom_range(0, 1));
      end
      clear = ($urandom_range(0, 399) == 0);
      tick();
      clear = 1'b0;
      chk("rnd_valid", ofm_valid, m_valid);
      if (m_valid) begin
        chk("rnd_data", ofm_data, m_data);
        chk("rnd_col", ofm_col, m_col);
        chk("rnd_last", ofm_last, m_last);
      end
      chk("rnd_ovf", overflow, m_ovf);
      chk("rnd_empty", empty, m_empty());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
